// File: rtl/msf_frame_assembler_if.sv
// rtl/msf_frame_assembler_if.sv - decoded-second stream from the MSF bit decoder
//
// Purpose : carries one decoded MSF second per strobe.
// Signals : valid        - one-cycle strobe, a decoded second is available
//           is_second_00 - qualifies valid: this second is the minute marker
//           data         - {B, A} bits for this second
// Modports: master (bit decoder side), slave (frame assembler side)

interface msf_frame_assembler_if;
  logic       valid;
  logic       is_second_00;
  logic [1:0] data;

  modport master (output valid, output is_second_00, output data);
  modport slave  (input  valid, input  is_second_00, input  data);
endinterface

// File: rtl/msf_frame_assembler.sv
// rtl/msf_frame_assembler.sv - MSF time-code frame assembler and validator
//
// Purpose : tracks the second index within the minute, captures the MSF
//           date/time field bits, parity bits and the 52A..59A marker word,
//           and at each minute marker publishes the validated time in BCD.
// Ports   : clk_i, rst_ni    - clock, asynchronous active-low reset
//           bits             - decoded-second stream (slave modport)
//           year_o..minute_o - last validated date/time (BCD, weekday binary)
//           second_o         - current second index 0..59
//           synced_o         - level, locked to minute markers
//           time_valid_o     - one-cycle pulse, time outputs just updated
//           frame_error_o    - one-cycle pulse, frame rejected or sync lost

module msf_frame_assembler #(
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  msf_frame_assembler_if.slave        bits,
  output logic [7:0]                  year_o,
  output logic [4:0]                  month_o,
  output logic [5:0]                  day_o,
  output logic [2:0]                  weekday_o,
  output logic [5:0]                  hour_o,
  output logic [6:0]                  minute_o,
  output logic [5:0]                  second_o,
  output logic                        synced_o,
  output logic                        time_valid_o,
  output logic                        frame_error_o
);

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_t;

  localparam logic [7:0] MARKER_WORD = 8'b0111_1110;

  state_t      state_q, state_d;
  logic [5:0]  sec_q, sec_d;
  logic        synced_q, synced_d;
  logic        tv_q, tv_d;
  logic        fe_q, fe_d;
  logic        load_time;
  logic        capture_en;

  // Capture registers: 35 field bits (17A..51A), parity 54B..57B, marker 52A..59A.
  logic [34:0] field_q;
  logic [3:0]  parity_q;
  logic [7:0]  marker_q;

  logic [7:0]  year_q;
  logic [4:0]  month_q;
  logic [5:0]  day_q;
  logic [2:0]  weekday_q;
  logic [5:0]  hour_q;
  logic [6:0]  minute_q;

  // Field decode; bit 17A ends up in field_q[34] after 35 MSB-first shifts.
  logic [7:0]  f_year;
  logic [4:0]  f_month;
  logic [5:0]  f_day;
  logic [2:0]  f_weekday;
  logic [5:0]  f_hour;
  logic [6:0]  f_minute;

  assign f_year    = field_q[34:27];
  assign f_month   = field_q[26:22];
  assign f_day     = field_q[21:16];
  assign f_weekday = field_q[15:13];
  assign f_hour    = field_q[12:7];
  assign f_minute  = field_q[6:0];

  logic count_ok, marker_ok, parity_ok, bcd_ok, value_ok, range_ok, frame_ok;

  assign count_ok  = (sec_q == 6'd59);
  assign marker_ok = (marker_q == MARKER_WORD);

  // Odd parity: data bits XOR parity bit must be 1 for every group.
  assign parity_ok = ((^f_year) ^ parity_q[0])
                   & ((^{f_month, f_day}) ^ parity_q[1])
                   & ((^f_weekday) ^ parity_q[2])
                   & ((^{f_hour, f_minute}) ^ parity_q[3]);

  // Only nibbles wide enough to exceed 9 need the digit check.
  assign bcd_ok = (f_year[7:4] <= 4'd9) && (f_year[3:0] <= 4'd9)
               && (f_month[3:0] <= 4'd9) && (f_day[3:0] <= 4'd9)
               && (f_hour[3:0] <= 4'd9) && (f_minute[3:0] <= 4'd9);

  // With valid digits, BCD values order the same as their binary encoding.
  assign value_ok = (f_month != 5'h00) && (f_month <= 5'h12)
                 && (f_day != 6'h00) && (f_day <= 6'h31)
                 && (f_weekday <= 3'd6)
                 && (f_hour <= 6'h23)
                 && (f_minute <= 7'h59);

  assign range_ok = !RANGE_CHECK || (bcd_ok && value_ok);
  assign frame_ok = count_ok && marker_ok && parity_ok && range_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_UNSYNC;
      sec_q    <= '0;
      synced_q <= 1'b0;
      tv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      synced_q <= synced_d;
      tv_q     <= tv_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    synced_d   = synced_q;
    tv_d       = 1'b0;
    fe_d       = 1'b0;
    load_time  = 1'b0;
    capture_en = 1'b0;
    if (bits.valid) begin
      if (bits.is_second_00) begin
        sec_d   = '0;
        state_d = ST_SYNC;
        // A marker seen while unsynced only starts a frame; nothing to judge yet.
        if (state_q == ST_SYNC) begin
          if (frame_ok) begin
            tv_d      = 1'b1;
            synced_d  = 1'b1;
            load_time = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end else if (state_q == ST_SYNC) begin
        if (sec_q == 6'd59) begin
          state_d  = ST_UNSYNC;
          synced_d = 1'b0;
          fe_d     = 1'b1;
          sec_d    = '0;
        end else begin
          sec_d      = sec_q + 6'd1;
          capture_en = 1'b1;
        end
      end
    end
  end

  // Bits belong to the new index, i.e. the incremented counter value.
  logic [5:0] cap_idx, par_idx, mrk_idx;
  assign cap_idx = sec_q + 6'd1;
  assign par_idx = cap_idx - 6'd54;
  assign mrk_idx = cap_idx - 6'd52;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      field_q  <= '0;
      parity_q <= '0;
      marker_q <= '0;
    end else if (capture_en) begin
      if (cap_idx >= 6'd17 && cap_idx <= 6'd51) begin
        field_q <= {field_q[33:0], bits.data[0]};
      end
      if (cap_idx >= 6'd54 && cap_idx <= 6'd57) begin
        parity_q[par_idx[1:0]] <= bits.data[1];
      end
      if (cap_idx >= 6'd52) begin
        // 52A lands in the MSB so the word reads 52A..59A left to right.
        marker_q[3'd7 - mrk_idx[2:0]] <= bits.data[0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      year_q    <= '0;
      month_q   <= '0;
      day_q     <= '0;
      weekday_q <= '0;
      hour_q    <= '0;
      minute_q  <= '0;
    end else if (load_time) begin
      year_q    <= f_year;
      month_q   <= f_month;
      day_q     <= f_day;
      weekday_q <= f_weekday;
      hour_q    <= f_hour;
      minute_q  <= f_minute;
    end
  end

  assign year_o        = year_q;
  assign month_o       = month_q;
  assign day_o         = day_q;
  assign weekday_o     = weekday_q;
  assign hour_o        = hour_q;
  assign minute_o      = minute_q;
  assign second_o      = sec_q;
  assign synced_o      = synced_q;
  assign time_valid_o  = tv_q;
  assign frame_error_o = fe_q;

endmodule

// File: tb/tb_msf_frame_assembler.sv
// tb/tb_msf_frame_assembler.sv - self-checking bench for msf_frame_assembler

module tb_msf_frame_assembler;

  logic clk;
  logic rst_n;
  msf_frame_assembler_if bus ();

  logic [7:0] year_w [2];
  logic [4:0] month_w [2];
  logic [5:0] day_w [2];
  logic [2:0] wd_w [2];
  logic [5:0] hour_w [2];
  logic [6:0] min_w [2];
  logic [5:0] sec_w [2];
  logic       synced_w [2];
  logic       tv_w [2];
  logic       fe_w [2];

  // Instance 0 range-checks BCD fields, instance 1 does not.
  msf_frame_assembler #(.RANGE_CHECK(1'b1)) dut_rc (
    .clk_i(clk), .rst_ni(rst_n), .bits(bus),
    .year_o(year_w[0]), .month_o(month_w[0]), .day_o(day_w[0]),
    .weekday_o(wd_w[0]), .hour_o(hour_w[0]), .minute_o(min_w[0]),
    .second_o(sec_w[0]), .synced_o(synced_w[0]),
    .time_valid_o(tv_w[0]), .frame_error_o(fe_w[0])
  );

  msf_frame_assembler #(.RANGE_CHECK(1'b0)) dut_nrc (
    .clk_i(clk), .rst_ni(rst_n), .bits(bus),
    .year_o(year_w[1]), .month_o(month_w[1]), .day_o(day_w[1]),
    .weekday_o(wd_w[1]), .hour_o(hour_w[1]), .minute_o(min_w[1]),
    .second_o(sec_w[1]), .synced_o(synced_w[1]),
    .time_valid_o(tv_w[1]), .frame_error_o(fe_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit         m_in_sync;
  int         m_cnt;
  logic [7:0] e_year [2];
  logic [4:0] e_month [2];
  logic [5:0] e_day [2];
  logic [2:0] e_wd [2];
  logic [5:0] e_hour [2];
  logic [6:0] e_min [2];
  logic       e_synced [2];
  logic       e_tv [2];
  logic       e_fe [2];

  // Frame being transmitted.
  logic [7:0]  f_year;
  logic [4:0]  f_month;
  logic [5:0]  f_day;
  logic [2:0]  f_wd;
  logic [5:0]  f_hour;
  logic [6:0]  f_min;
  logic [3:0]  f_parflip;
  bit          f_markbad;
  logic [59:0] fa;
  logic [59:0] fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string where);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d year", where, k),   32'(year_w[k]),   32'(e_year[k]));
      chk($sformatf("%s d%0d month", where, k),  32'(month_w[k]),  32'(e_month[k]));
      chk($sformatf("%s d%0d day", where, k),    32'(day_w[k]),    32'(e_day[k]));
      chk($sformatf("%s d%0d wday", where, k),   32'(wd_w[k]),     32'(e_wd[k]));
      chk($sformatf("%s d%0d hour", where, k),   32'(hour_w[k]),   32'(e_hour[k]));
      chk($sformatf("%s d%0d minute", where, k), 32'(min_w[k]),    32'(e_min[k]));
      chk($sformatf("%s d%0d second", where, k), 32'(sec_w[k]),    32'(m_cnt));
      chk($sformatf("%s d%0d synced", where, k), 32'(synced_w[k]), 32'(e_synced[k]));
      chk($sformatf("%s d%0d tvalid", where, k), 32'(tv_w[k]),     32'(e_tv[k]));
      chk($sformatf("%s d%0d ferr", where, k),   32'(fe_w[k]),     32'(e_fe[k]));
    end
  endtask

  task automatic model_reset();
    m_in_sync = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      e_year[k] = '0; e_month[k] = '0; e_day[k] = '0; e_wd[k] = '0;
      e_hour[k] = '0; e_min[k] = '0; e_synced[k] = 1'b0;
      e_tv[k] = 1'b0; e_fe[k] = 1'b0;
    end
  endtask

  // Decimal value of a two-digit BCD byte, -1 when a digit is not 0..9.
  function automatic int dec2(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit range_ok_m();
    int y, mo, d, h, mi;
    y  = dec2(f_year);
    mo = dec2({3'b000, f_month});
    d  = dec2({2'b00, f_day});
    h  = dec2({2'b00, f_hour});
    mi = dec2({1'b0, f_min});
    return (y >= 0) && (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= 31)
        && (f_wd <= 3'd6) && (h >= 0) && (h <= 23) && (mi >= 0) && (mi <= 59);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Lay the frame out over seconds 0..59; unused positions carry noise.
  task automatic build();
    logic [34:0] fv;
    fv = {f_year, f_month, f_day, f_wd, f_hour, f_min};
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    for (int i = 0; i < 35; i++) fa[17 + i] = fv[34 - i];
    fa[52] = 1'b0;
    for (int i = 53; i <= 58; i++) fa[i] = 1'b1;
    fa[59] = 1'b0;
    if (f_markbad) fa[52 + $urandom_range(0, 7)] ^= 1'b1;
    fb[54] = ~(^f_year) ^ f_parflip[0];
    fb[55] = ~(^{f_month, f_day}) ^ f_parflip[1];
    fb[56] = ~(^f_wd) ^ f_parflip[2];
    fb[57] = ~(^{f_hour, f_min}) ^ f_parflip[3];
  endtask

  // One decoded-second strobe, model update, then check all outputs.
  task automatic step(input bit marker, input int idx, input string where);
    bit pass;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.is_second_00 = marker;
    bus.data = marker ? 2'b11 : {fb[idx], fa[idx]};
    for (int k = 0; k < 2; k++) begin
      e_tv[k] = 1'b0;
      e_fe[k] = 1'b0;
    end
    if (marker) begin
      if (m_in_sync) begin
        for (int k = 0; k < 2; k++) begin
          pass = (m_cnt == 59) && !f_markbad && (f_parflip == 4'd0) && (k == 1 || range_ok_m());
          if (pass) begin
            e_year[k] = f_year; e_month[k] = f_month; e_day[k] = f_day;
            e_wd[k] = f_wd; e_hour[k] = f_hour; e_min[k] = f_min;
            e_synced[k] = 1'b1; e_tv[k] = 1'b1;
          end else begin
            e_fe[k] = 1'b1;
          end
        end
      end
      m_cnt = 0;
      m_in_sync = 1'b1;
    end else if (m_in_sync) begin
      if (m_cnt == 59) begin
        m_in_sync = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
          e_synced[k] = 1'b0;
          e_fe[k] = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk_all(where);
    bus.valid = 1'b0;
    bus.is_second_00 = 1'b0;
  endtask

  task automatic send_frame(input int nsec, input string where);
    build();
    for (int i = 1; i <= nsec; i++) step(1'b0, i % 60, where);
    step(1'b1, 0, {where, " marker"});
  endtask

  task automatic set_fields(input logic [7:0] y, input logic [4:0] mo, input logic [5:0] d,
                            input logic [2:0] wd, input logic [5:0] h, input logic [6:0] mi);
    f_year = y; f_month = mo; f_day = d; f_wd = wd; f_hour = h; f_min = mi;
    f_parflip = 4'd0;
    f_markbad = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.valid = 1'b0;
    bus.is_second_00 = 1'b0;
    bus.data = 2'b00;
    fa = '0;
    fb = '0;
    set_fields(8'h00, 5'h00, 6'h00, 3'd0, 6'h00, 7'h00);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Strobes before any marker are ignored.
    for (int i = 1; i <= 30; i++) step(1'b0, i, "unsync");
    step(1'b1, 0, "first marker");

    // 2023-06-15, weekday 4, 14:37.
    set_fields(8'h23, 5'h06, 6'h15, 3'd4, 6'h14, 7'h37);
    send_frame(59, "good frame");
    chk("tp1 year", 32'(year_w[0]), 32'h23);
    chk("tp1 hour", 32'(hour_w[0]), 32'h14);

    // Parity error on month+day group.
    f_parflip = 4'b0010;
    send_frame(59, "parity 55B");

    // Hour 0x25 with good parity: only the range-checking instance rejects it.
    set_fields(8'h23, 5'h06, 6'h15, 3'd4, 6'h25, 7'h37);
    send_frame(59, "hour 25");
    chk("tp6 hour nrc", 32'(hour_w[1]), 32'h25);

    // Short minute.
    set_fields(8'h24, 5'h01, 6'h01, 3'd0, 6'h00, 7'h00);
    send_frame(58, "short frame");

    // Overflow: 60 strobes without a marker, then resync.
    build();
    for (int i = 1; i <= 60; i++) step(1'b0, i % 60, "overflow");
    step(1'b1, 0, "resync marker");
    set_fields(8'h99, 5'h12, 6'h31, 3'd6, 6'h23, 7'h59);
    send_frame(59, "max frame");

    // Randomised frames.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        set_fields(8'($urandom), 5'($urandom), 6'($urandom), 3'($urandom), 6'($urandom), 7'($urandom));
      end else begin
        set_fields(to_bcd($urandom_range(0, 99)), 5'(to_bcd($urandom_range(1, 12))),
                   6'(to_bcd($urandom_range(1, 31))), 3'($urandom_range(0, 6)),
                   6'(to_bcd($urandom_range(0, 23))), 7'(to_bcd($urandom_range(0, 59))));
      end
      if ($urandom_range(0, 5) == 0) f_parflip = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) f_markbad = 1'b1;
      send_frame(($urandom_range(0, 7) == 0) ? 58 : 59, $sformatf("rand%0d", n));
    end

    // Asynchronous reset in mid-minute.
    set_fields(8'h30, 5'h10, 6'h20, 3'd2, 6'h08, 7'h15);
    build();
    for (int i = 1; i <= 20; i++) step(1'b0, i, "pre reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 0, "post reset marker");
    send_frame(59, "post reset frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msf_frame_assembler.md
Name: msf_frame_assembler

Overview:
Downstream consumer of the per-second bit decoder. It takes each decoded second (valid strobe, second-00 flag, {B,A} bits) and tracks the second index within the minute. It collects the MSF time-code fields and checks parity, the 52A–59A marker word and BCD ranges. At each minute marker it publishes the validated date/time in BCD, which feeds the display/clock-keeping stage.

Parameters:
RANGE_CHECK, 1, when 1 reject frames whose BCD fields are out of range; when 0 only parity and marker checks apply.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
bits_valid_i  input  1  one-cycle strobe: a decoded second is available
bits_is_second_00_i  input  1  qualifies bits_valid_i: this second is the minute marker
bits_data_i  input  2  {B, A} bits for this second
year_o  output  8  BCD year 00–99
month_o  output  5  BCD month
day_o  output  6  BCD day of month
weekday_o  output  3  weekday 0–6
hour_o  output  6  BCD hour
minute_o  output  7  BCD minute
second_o  output  6  current second index 0–59 (binary)
synced_o  output  1  level: locked to minute markers
time_valid_o  output  1  one-cycle pulse: time outputs just updated
frame_error_o  output  1  one-cycle pulse: frame rejected or sync lost

Behaviour:
- Reset:
  - All outputs are 0.
  - State is UNSYNC; second counter is 0; capture registers are 0.
- Event: clk_i rising edge with bits_valid_i=1. All other cycles hold state.
- Marker event (bits_is_second_00_i=1), in any state:
  - Second counter ← 0 and state ← SYNC.
  - If the previous state was SYNC, the frame is checked (below).
  - Pass: on the next cycle, time outputs load from the capture registers, time_valid_o pulses and synced_o=1.
  - Fail: frame_error_o pulses and time outputs hold.
- Non-marker event in UNSYNC: ignored; counter holds.
- Non-marker event in SYNC with counter<59: counter increments. The bits are stored at the new index n.
  - A bit at n=17..51 shifts into a 35-bit field register, MSB-first.
  - B bit at n=54..57 goes to parity slot n-54.
  - A bit at n=52..59 goes into an 8-bit marker word.
- Non-marker event in SYNC with counter=59 (overflow):
  - State ← UNSYNC, synced_o ← 0, frame_error_o pulses, counter ← 0.
- Field layout (bit weights MSB first):
  - year 17–24: 80,40,20,10,8,4,2,1
  - month 25–29: 10,8,4,2,1
  - day 30–35: 20,10,8,4,2,1
  - weekday 36–38: 4,2,1
  - hour 39–44: 20,10,8,4,2,1
  - minute 45–51: 40,20,10,8,4,2,1
- Frame check at marker; all conditions must hold:
  - counter==59 (exactly 60 seconds seen; leap-second minutes are rejected).
  - Marker word (52A..59A) == 01111110.
  - Odd parity: XOR of the data bits and the parity bit == 1 for each group:
    - year with 54B
    - month+day with 55B
    - weekday with 56B
    - hour+minute with 57B
  - If RANGE_CHECK=1:
    - every BCD nibble ≤9
    - month 01–12, day 01–31, weekday ≤6, hour 00–23, minute 00–59
- Output/flag behaviour:
  - second_o mirrors the counter combinationally from the register.
  - synced_o=1 from the first passing frame until overflow or reset; a failed frame alone does not clear it.
  - time_valid_o and frame_error_o are registered, never both high, with latency 1 cycle after the marker event.
- Reset is asynchronous and may assert at any time, mid-minute included; state returns to the reset values.

Test Plan:
1. Reset then marker, 59 seconds encoding 2023-06-15 weekday 4 14:37, with 54B–57B=0, 52A–59A=01111110, then marker:
   - time_valid_o pulses once.
   - year_o=0x23, month_o=0x06, day_o=0x15, weekday_o=4, hour_o=0x14, minute_o=0x37, synced_o=1.
2. Same frame with 55B=1 → frame_error_o pulses, outputs hold the previous values, synced_o unchanged.
3. Before any marker, 30 non-marker strobes → second_o stays 0, no pulses, synced_o=0.
4. After sync, 60 non-marker strobes without a marker → on the 60th, frame_error_o pulses, synced_o=0, second_o=0; the next marker re-enters SYNC.
5. Frame with only 58 non-marker seconds before the marker → frame_error_o pulses; the counter restarts at 0.
6. RANGE_CHECK=1, valid parity, hour field 0x25 → frame_error_o pulses. With RANGE_CHECK=0, the same frame gives time_valid_o and hour_o=0x25.
